fetch_decode: RTL

FETCH_DECODE -- requirements
Module: fetch_decode

---
 rtl/fetch_decode_pkg.sv | 53 +++++
 rtl/instr_decode.sv | 51 +++++
 rtl/fetch_decode.sv | 118 +++++++++++
 3 files changed

// File: rtl/fetch_decode_pkg.sv
// Shared definitions for the fetch/decode block: instruction field layout,
// FSM states, reset PC default and the decoded-control bundle.
package fetch_decode_pkg;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  // Instruction field positions (LSB of each field) and single-bit flags.
  localparam int OP_LSB   = 29;
  localparam int OP_W     = 3;
  localparam int FORM_BIT = 28;
  localparam int VEC_LSB  = 26;
  localparam int VEC_W    = 2;
  localparam int A_LSB    = 22;
  localparam int B_LSB    = 18;
  localparam int C_LSB    = 14;
  localparam int D_LSB    = 10;
  localparam int Y1_LSB   = 6;
  localparam int Y2_LSB   = 2;
  localparam int REG_W    = 4;
  localparam int IMM_BIT  = 1;
  localparam int HALT_BIT = 0;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_WAIT_I,
    ST_REQ_C,
    ST_WAIT_C,
    ST_ISSUE,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic             form;
    logic [VEC_W-1:0] vec;
    logic [REG_W-1:0] a;
    logic [REG_W-1:0] b;
    logic [REG_W-1:0] c;
    logic [REG_W-1:0] d;
    logic [REG_W-1:0] y1;
    logic [REG_W-1:0] y2;
    logic [3:0]       zero_reg;
    logic [1:0]       write;
    logic             const_a;
    logic [31:0]      constant;
  } ctrl_t;

  // The HALT bit never reaches the decoder, so the latched word is [31:1].
  function automatic logic [REG_W-1:0] reg_field(input logic [31:1] w, input int lsb);
    return w[lsb +: REG_W];
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Purely combinational decode of the latched instruction into datapath
// controls. Fields read as zero whenever fields_valid is low.
module instr_decode
  import fetch_decode_pkg::*;
(
  input  logic [31:1] word,
  input  logic [31:0] immediate,
  input  logic        issue,
  input  logic        fields_valid,
  output ctrl_t       ctrl
);

  logic             imm;
  logic [REG_W-1:0] fa, fb, fc, fd, fy1, fy2;

  always_comb begin
    imm = word[IMM_BIT];
    fa  = reg_field(word, A_LSB);
    fb  = reg_field(word, B_LSB);
    fc  = reg_field(word, C_LSB);
    fd  = reg_field(word, D_LSB);
    fy1 = reg_field(word, Y1_LSB);
    fy2 = reg_field(word, Y2_LSB);

    ctrl = '0;
    if (fields_valid) begin
      ctrl.op   = word[OP_LSB +: OP_W];
      ctrl.form = word[FORM_BIT];
      ctrl.vec  = word[VEC_LSB +: VEC_W];
      ctrl.a    = fa;
      ctrl.b    = fb;
      ctrl.c    = fc;
      ctrl.d    = fd;
      ctrl.y1   = fy1;
      ctrl.y2   = fy2;

      // Operand A is replaced by the immediate, so it is never the zero register.
      ctrl.zero_reg[0] = (fa == '0) && !imm;
      ctrl.zero_reg[1] = (fb == '0);
      ctrl.zero_reg[2] = (fc == '0);
      ctrl.zero_reg[3] = (fd == '0);

      ctrl.write[0] = issue && (fy1 != '0);
      ctrl.write[1] = issue && (fy2 != '0);

      ctrl.const_a  = imm;
      ctrl.constant = imm ? immediate : 32'h0;
    end
  end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode front end: request-response fetch FSM with optional
// immediate word, PC, issue handshake with downstream stall, and HALT.
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  input  logic        stall,
  output logic [2:0]  op,
  output logic        form,
  output logic [1:0]  vec,
  output logic [3:0]  A,
  output logic [3:0]  B,
  output logic [3:0]  C,
  output logic [3:0]  D,
  output logic [3:0]  Y1,
  output logic [3:0]  Y2,
  output logic [3:0]  zero_reg,
  output logic [1:0]  write,
  output logic        const_a,
  output logic [31:0] constant,
  output logic        program_counter_inc,
  output logic        issue,
  output logic        halted
);

  state_t      state, state_d;
  logic [15:0] pc, pc_d;
  logic [31:1] ir, ir_d;
  logic [31:0] cst, cst_d;
  logic        in_issue;
  ctrl_t       ctrl;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      cst   <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      ir    <= ir_d;
      cst   <= cst_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    ir_d    = ir;
    cst_d   = cst;
    unique case (state)
      ST_FETCH:  state_d = ST_WAIT_I;
      ST_WAIT_I: begin
        if (imem_valid) begin
          ir_d = imem_data[31:1];
          pc_d = pc + 16'd1;
          if (imem_data[HALT_BIT])     state_d = ST_HALT;
          else if (imem_data[IMM_BIT]) state_d = ST_REQ_C;
          else                         state_d = ST_ISSUE;
        end
      end
      ST_REQ_C:  state_d = ST_WAIT_C;
      ST_WAIT_C: begin
        if (imem_valid) begin
          cst_d   = imem_data;
          pc_d    = pc + 16'd1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE:  if (!stall) state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Outputs are gated by rst so nothing leaks while reset is held.
  assign in_issue            = (state == ST_ISSUE) && !rst;
  assign issue               = in_issue && !stall;
  assign program_counter_inc = issue;
  assign imem_req            = ((state == ST_FETCH) || (state == ST_REQ_C)) && !rst;
  assign imem_addr           = pc;
  assign halted              = (state == ST_HALT) && !rst;

  instr_decode u_decode (
    .word         (ir),
    .immediate    (cst),
    .issue        (issue),
    .fields_valid (in_issue),
    .ctrl         (ctrl)
  );

  assign op       = ctrl.op;
  assign form     = ctrl.form;
  assign vec      = ctrl.vec;
  assign A        = ctrl.a;
  assign B        = ctrl.b;
  assign C        = ctrl.c;
  assign D        = ctrl.d;
  assign Y1       = ctrl.y1;
  assign Y2       = ctrl.y2;
  assign zero_reg = ctrl.zero_reg;
  assign write    = ctrl.write;
  assign const_a  = ctrl.const_a;
  assign constant = ctrl.constant;

endmodule
